// File: rtl/reg_file_bank.sv
// reg_file_bank: DEPTH x WIDTH register bank with global clock enable,
// byte-masked writes, two registered read ports (write-first or read-first)
// and a single-cycle shadow bank for save / restore / swap of the whole set.
module reg_file_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_enable,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_a,
  output logic [WIDTH-1:0]     rd_data_b,
  input  logic                 save,
  input  logic                 restore,
  output logic                 shadow_valid,
  output logic                 restore_err
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] main_q   [DEPTH];
  logic [WIDTH-1:0] main_d   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             do_restore;

  // Next-state: save/restore/swap phase, then byte-masked write, then reads.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      main_d[i]   = main_q[i];
      shadow_d[i] = shadow_q[i];
    end
    rd_a_d     = rd_a_q;
    rd_b_d     = rd_b_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    do_restore = 1'b0;

    if (c_enable) begin
      // A restore without a saved image is dropped and flagged.
      do_restore = restore & valid_q;
      err_d      = restore & ~valid_q;
      valid_d    = valid_q | save;

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (save && do_restore) begin
          main_d[i]   = shadow_q[i];
          shadow_d[i] = main_q[i];
        end else if (save) begin
          shadow_d[i] = main_q[i];
        end else if (do_restore) begin
          main_d[i]   = shadow_q[i];
        end
      end

      // The write lands on top of the phase-1 result, so it wins over restore.
      if (wr_en) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (wr_be[b]) begin
            main_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end

      if (ZERO_REG) begin
        main_d[0]   = '0;
        shadow_d[0] = '0;
      end

      if (BYPASS) begin
        rd_a_d = main_d[rd_addr_a];
        rd_b_d = main_d[rd_addr_b];
      end else begin
        rd_a_d = main_q[rd_addr_a];
        rd_b_d = main_q[rd_addr_b];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        main_q[i]   <= main_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rd_data_a    = rd_a_q;
  assign rd_data_b    = rd_b_q;
  assign shadow_valid = valid_q;
  assign restore_err  = err_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: a write-first (BYPASS=1) and a read-first
// (BYPASS=0) instance share one stimulus stream.
module tb_reg_file_bank;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset, c_enable, wr_en, save, restore;
  logic [ADDR_W-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0]  wr_data;
  logic [1:0]        wr_be;

  logic [WIDTH-1:0]  wf_rd_a, wf_rd_b, rf_rd_a, rf_rd_b;
  logic              wf_valid, wf_err, rf_valid, rf_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                  .ZERO_REG(1'b1), .BYPASS(1'b1)) u_wf (
    .clk(clk), .reset(reset), .c_enable(c_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(wf_rd_a), .rd_data_b(wf_rd_b),
    .save(save), .restore(restore),
    .shadow_valid(wf_valid), .restore_err(wf_err)
  );

  reg_file_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                  .ZERO_REG(1'b1), .BYPASS(1'b0)) u_rf (
    .clk(clk), .reset(reset), .c_enable(c_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rf_rd_a), .rd_data_b(rf_rd_b),
    .save(save), .restore(restore),
    .shadow_valid(rf_valid), .restore_err(rf_err)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                    input logic [1:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
  endtask

  initial begin
    reset = 1'b1; c_enable = 1'b1; wr_en = 1'b0; save = 1'b0; restore = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr_a = '0; rd_addr_b = '0;
    step();
    step();
    chk("reset_valid", 16'(wf_valid), 16'(0));
    chk("reset_err", 16'(wf_err), 16'(0));
    reset = 1'b0;

    // Every address reads 0 after reset on both ports.
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr_a = ADDR_W'(i);
      rd_addr_b = ADDR_W'(DEPTH - 1 - i);
      step();
      chk("reset_rd_a", wf_rd_a, 16'h0000);
      chk("reset_rd_b", wf_rd_b, 16'h0000);
      chk("reset_rf_rd_a", rf_rd_a, 16'h0000);
    end

    // Byte-masked merge on r3; bypass vs read-first.
    wr(3'd3, 16'h1234, 2'b11);
    step();
    wr(3'd3, 16'hABCD, 2'b01);
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    step();
    chk("merge_wf_a", wf_rd_a, 16'h12CD);
    chk("merge_wf_b", wf_rd_b, 16'h12CD);
    chk("merge_rf_a", rf_rd_a, 16'h1234);
    wr_en = 1'b0;
    step();
    chk("merge_rf_a_late", rf_rd_a, 16'h12CD);
    chk("merge_wf_a_hold", wf_rd_a, 16'h12CD);

    // Restore with no saved image: one-cycle error pulse, bank untouched.
    restore = 1'b1;
    step();
    chk("rerr_pulse", 16'(wf_err), 16'(1));
    chk("rerr_valid", 16'(wf_valid), 16'(0));
    chk("rerr_r3", wf_rd_a, 16'h12CD);
    restore = 1'b0;
    step();
    chk("rerr_clear", 16'(wf_err), 16'(0));

    // Save, overwrite, restore r1.
    wr(3'd1, 16'h1111, 2'b11);
    rd_addr_a = 3'd1;
    step();
    wr_en = 1'b0; save = 1'b1;
    step();
    chk("save_valid", 16'(wf_valid), 16'(1));
    save = 1'b0;
    wr(3'd1, 16'h2222, 2'b11);
    step();
    chk("ovw_r1", wf_rd_a, 16'h2222);
    chk("ovw_valid", 16'(wf_valid), 16'(1));
    wr_en = 1'b0; restore = 1'b1;
    step();
    chk("restore_wf_r1", wf_rd_a, 16'h1111);
    chk("restore_rf_r1", rf_rd_a, 16'h2222);
    chk("restore_valid", 16'(wf_valid), 16'(1));
    chk("restore_noerr", 16'(wf_err), 16'(0));
    restore = 1'b0;
    step();
    chk("restore_rf_r1_late", rf_rd_a, 16'h1111);

    // Swap with a same-cycle write on r2.
    wr(3'd2, 16'h5555, 2'b11);
    step();
    wr_en = 1'b0; save = 1'b1;
    step();
    save = 1'b0;
    wr(3'd2, 16'hAAAA, 2'b11);
    step();
    wr(3'd2, 16'h0F0F, 2'b11);
    save = 1'b1; restore = 1'b1; rd_addr_a = 3'd2;
    step();
    chk("swap_main_r2", wf_rd_a, 16'h0F0F);
    chk("swap_valid", 16'(wf_valid), 16'(1));
    chk("swap_noerr", 16'(wf_err), 16'(0));
    wr_en = 1'b0; save = 1'b0; restore = 1'b1;
    step();
    chk("swap_shadow_r2", wf_rd_a, 16'hAAAA);
    restore = 1'b0;

    // All-zero byte enables change nothing.
    wr(3'd2, 16'hFFFF, 2'b00);
    step();
    chk("be_zero", wf_rd_a, 16'hAAAA);
    wr_en = 1'b0;

    // Clock enable low freezes everything.
    c_enable = 1'b0;
    wr(3'd2, 16'h1234, 2'b11);
    save = 1'b1; restore = 1'b1; rd_addr_a = 3'd3;
    step();
    chk("cen_rd_hold", wf_rd_a, 16'hAAAA);
    chk("cen_valid", 16'(wf_valid), 16'(1));
    chk("cen_err", 16'(wf_err), 16'(0));
    c_enable = 1'b1; wr_en = 1'b0; save = 1'b0; restore = 1'b0;
    rd_addr_a = 3'd2;
    step();
    chk("cen_r2_unchanged", wf_rd_a, 16'hAAAA);

    // Register 0 ignores writes.
    wr(3'd0, 16'hFFFF, 2'b11);
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    step();
    chk("zero_wf", wf_rd_a, 16'h0000);
    wr_en = 1'b0;
    step();
    chk("zero_rf", rf_rd_b, 16'h0000);

    // Save sampled with reset is discarded; swap with no image acts as save.
    reset = 1'b1; save = 1'b1;
    step();
    chk("rst_save_valid", 16'(wf_valid), 16'(0));
    reset = 1'b0; save = 1'b1; restore = 1'b1;
    step();
    chk("swap_nov_err", 16'(wf_err), 16'(1));
    chk("swap_nov_valid", 16'(wf_valid), 16'(1));
    save = 1'b0; restore = 1'b0;
    step();
    chk("swap_nov_err_clr", 16'(rf_err), 16'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
